pc_fetch_ctrl: RTL and testbench



---
 rtl/pc_fetch_ctrl.sv | 96 +++++++++
 tb/tb_pc_fetch_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl.sv
// Instruction-fetch and program-counter controller for the 16-bit accumulator core.
// Fetches over a req/ack handshake, hands the IR to decode, and reloads PC from the external mux.
module pc_fetch_ctrl #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned OFFSET_W = 12
) (
  input  logic        CLK,
  input  logic        Reset_n,
  output logic [15:0] Mem_Addr,
  output logic        Mem_Req,
  input  logic        Mem_Ack,
  input  logic [15:0] Mem_Data,
  output logic [15:0] Instr,
  output logic        Instr_Valid,
  input  logic        Instr_Ready,
  input  logic        Resolve,
  input  logic        Branch_Taken,
  output logic [15:0] PC_Next_Seq,
  output logic [15:0] PC_Branch,
  output logic        PC_Sel,
  input  logic [15:0] PC_In,
  output logic [15:0] PC
);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StHold,
    StResolve,
    StUpdate
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic        sel_q, sel_d;
  logic [15:0] off_ext;

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      ir_q    <= 16'h0000;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      sel_q   <= sel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    sel_d   = sel_q;
    unique case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        if (Mem_Ack) begin
          ir_d    = Mem_Data;
          state_d = StHold;
        end
      end
      StHold: begin
        if (Instr_Ready) state_d = StResolve;
      end
      StResolve: begin
        if (Resolve) begin
          sel_d   = Branch_Taken;
          state_d = StUpdate;
        end
      end
      StUpdate: begin
        pc_d    = PC_In;
        sel_d   = 1'b0;
        state_d = StFetch;
      end
      default: state_d = StIdle;
    endcase
  end

  // Word offset: sign-extend to 16 bits, then scale to bytes.
  assign off_ext     = 16'($signed(ir_q[OFFSET_W-1:0]));
  assign PC_Next_Seq = pc_q + 16'd2;
  assign PC_Branch   = pc_q + 16'd2 + {off_ext[14:0], 1'b0};

  assign PC          = pc_q;
  assign Mem_Addr    = pc_q;
  assign Instr       = ir_q;
  assign Mem_Req     = (state_q == StFetch);
  assign Instr_Valid = (state_q == StHold);
  assign PC_Sel      = (state_q == StUpdate) && sel_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: scoreboard of expected fetch addresses,
// handshake stalls, branch/wrap arithmetic and asynchronous mid-operation reset.
module tb_pc_fetch_ctrl;

  localparam logic [15:0] RPC = 16'h0100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] mem_addr, mem_data, instr, pc_next_seq, pc_branch, pc_in, pc;
  logic        mem_req, mem_ack, instr_valid, instr_ready, resolve, branch_taken, pc_sel;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // External 2-input PC-source mux.
  assign pc_in = pc_sel ? pc_branch : pc_next_seq;

  pc_fetch_ctrl #(
    .RESET_PC(RPC),
    .OFFSET_W(12)
  ) dut (
    .CLK         (clk),
    .Reset_n     (rst_n),
    .Mem_Addr    (mem_addr),
    .Mem_Req     (mem_req),
    .Mem_Ack     (mem_ack),
    .Mem_Data    (mem_data),
    .Instr       (instr),
    .Instr_Valid (instr_valid),
    .Instr_Ready (instr_ready),
    .Resolve     (resolve),
    .Branch_Taken(branch_taken),
    .PC_Next_Seq (pc_next_seq),
    .PC_Branch   (pc_branch),
    .PC_Sel      (pc_sel),
    .PC_In       (pc_in),
    .PC          (pc)
  );

  task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req"}, {15'd0, mem_req}, 16'd0);
    check_eq({tag, "_valid"}, {15'd0, instr_valid}, 16'd0);
    check_eq({tag, "_sel"}, {15'd0, pc_sel}, 16'd0);
    check_eq({tag, "_pc"}, pc, RPC);
    check_eq({tag, "_addr"}, mem_addr, RPC);
    check_eq({tag, "_instr"}, instr, 16'h0000);
  endtask

  // Releases reset at a negedge and waits (bounded) for the first FETCH cycle.
  task automatic release_and_wait_fetch();
    int n;
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_req && n < 10);
    check_eq("req_after_release", n[15:0], 16'd1);
    exp_q.delete();
    exp_q.push_back(RPC);
  endtask

  task automatic async_reset(input string tag);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs(tag);
    mem_ack = 1'b0; instr_ready = 1'b0; resolve = 1'b0; branch_taken = 1'b0;
    release_and_wait_fetch();
  endtask

  // Runs one instruction starting at a FETCH negedge. abort: 0 none, 1 stop in HOLD, 2 in RESOLVE.
  task automatic do_instr(input logic [15:0] iw, input bit taken, input int ack_dly,
                          input int rdy_dly, input int res_dly, input bit spurious,
                          input int abort);
    logic [15:0] pc_m, seq_m, br_m, off_m, ir_before;
    int c0;
    c0 = cyc;
    pc_m = exp_q.size() > 0 ? exp_q.pop_front() : 16'hxxxx;
    check_eq("fetch_addr", mem_addr, pc_m);
    check_eq("pc_eq_addr", pc, pc_m);
    check_eq("fetch_req", {15'd0, mem_req}, 16'd1);
    ir_before = instr;
    for (int i = 0; i < ack_dly; i++) begin
      mem_data = ~iw;
      instr_ready = spurious;
      @(negedge clk);
      check_eq("req_held", {15'd0, mem_req}, 16'd1);
      check_eq("ir_no_ack", instr, ir_before);
    end
    instr_ready = 1'b0;
    mem_ack = 1'b1;
    mem_data = iw;
    @(negedge clk);
    mem_ack = 1'b0;
    mem_data = 16'hDEAD;
    check_eq("ir_loaded", instr, iw);
    check_eq("hold_valid", {15'd0, instr_valid}, 16'd1);
    check_eq("hold_req", {15'd0, mem_req}, 16'd0);
    if (abort == 1) return;
    for (int i = 0; i < rdy_dly; i++) begin
      resolve = spurious;
      branch_taken = spurious;
      @(negedge clk);
      check_eq("ir_stall", instr, iw);
      check_eq("valid_stall", {15'd0, instr_valid}, 16'd1);
    end
    resolve = 1'b0;
    branch_taken = 1'b0;
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    off_m = {{4{iw[11]}}, iw[11:0]};
    seq_m = pc_m + 16'd2;
    br_m = seq_m + (off_m << 1);
    check_eq("resolve_valid", {15'd0, instr_valid}, 16'd0);
    check_eq("pc_next_seq", pc_next_seq, seq_m);
    check_eq("pc_branch", pc_branch, br_m);
    if (abort == 2) return;
    for (int i = 0; i < res_dly; i++) begin
      @(negedge clk);
      check_eq("sel_wait", {15'd0, pc_sel}, 16'd0);
    end
    resolve = 1'b1;
    branch_taken = taken;
    @(negedge clk);
    resolve = 1'b0;
    branch_taken = 1'b0;
    check_eq("update_sel", {15'd0, pc_sel}, {15'd0, taken});
    check_eq("update_pc_stable", pc, pc_m);
    exp_q.push_back(taken ? br_m : seq_m);
    @(negedge clk);
    check_eq("next_req", {15'd0, mem_req}, 16'd1);
    check_eq("next_sel", {15'd0, pc_sel}, 16'd0);
    check_eq("loop_cycles", 16'(cyc - c0), 16'(4 + ack_dly + rdy_dly + res_dly));
  endtask

  initial begin
    rst_n = 1'b0;
    mem_ack = 1'b0; mem_data = 16'h0000; instr_ready = 1'b0;
    resolve = 1'b0; branch_taken = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    release_and_wait_fetch();

    do_instr(16'h0010, 1'b0, 0, 0, 0, 1'b0, 0);  // 0100 -> 0102
    do_instr(16'h007E, 1'b1, 0, 0, 0, 1'b0, 0);  // 0102 -> 0200
    do_instr(16'h0FFE, 1'b1, 0, 0, 0, 1'b0, 0);  // 0200 -> 01FE (offset -2)
    do_instr(16'h0EFF, 1'b1, 0, 0, 0, 1'b0, 0);  // 01FE -> FFFE
    do_instr(16'hA123, 1'b0, 3, 2, 1, 1'b1, 0);  // FFFE -> 0000 wrap, stalls
    do_instr(16'h5555, 1'b0, 1, 0, 0, 1'b0, 1);  // reset while in HOLD
    async_reset("rst_hold");
    do_instr(16'h0001, 1'b0, 0, 0, 0, 1'b0, 0);  // 0100 -> 0102
    do_instr(16'h0F00, 1'b1, 0, 1, 0, 1'b0, 2);  // reset while in RESOLVE
    async_reset("rst_resolve");
    do_instr(16'h0003, 1'b1, 0, 0, 0, 1'b0, 0);  // 0100 -> 0108
    check_eq("final_addr", mem_addr, exp_q.size() > 0 ? exp_q[0] : 16'hxxxx);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
